// File: rtl/axis_frame_rx_pkg.sv
// Shared types and helpers for the axis_frame_rx frame receiver.
package axis_frame_rx_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

  // Widest tkeep the popcount helper handles (1024-bit data).
  localparam int KEEP_MAX = 128;

  function automatic int len_w(input int depth, input int keep_w);
    return $clog2(depth * keep_w + 1);
  endfunction

  function automatic int unsigned popcount(input logic [KEEP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KEEP_MAX; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/axis_frame_rx_ram.sv
// Frame word buffer: one write port, one registered read port, no storage reset.
module axis_frame_rx_ram #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_frame_rx.sv
// Terminating AXI4-Stream frame receiver with descriptor handshake and buffer read port.
// Define AXIS_FRAME_RX_ERR_FWD_EN to hand errored frames to the reader instead of dropping them.
module axis_frame_rx
  import axis_frame_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                 s_axis_tkeep,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0]                 s_axis_tuser,
  output logic                                  frm_valid,
  input  logic                                  frm_ready,
  output logic [len_w(DEPTH, KEEP_WIDTH)-1:0]   frm_len,
  output logic                                  frm_err,
  input  logic [$clog2(DEPTH)-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic [15:0]                           drop_cnt
);

`ifdef AXIS_FRAME_RX_ERR_FWD_EN
  localparam bit ERR_FWD = 1'b1;
`else
  localparam bit ERR_FWD = 1'b0;
`endif

  localparam int LEN_W = len_w(DEPTH, KEEP_WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int WC_W  = $clog2(DEPTH + 1);

  state_t              state;
  logic [WC_W-1:0]     wcnt;
  logic                err_sticky;
  logic                beat, full, err_now, we;
  logic [KEEP_WIDTH-1:0] keep_eff;
  logic [KEEP_MAX-1:0] keep_ext;
  logic [LEN_W-1:0]    len_calc;
  logic                unused_user;

  assign beat     = s_axis_tvalid && s_axis_tready;
  assign full     = (wcnt == WC_W'(DEPTH));
  assign err_now  = err_sticky || s_axis_tuser[0];
  assign keep_eff = KEEP_ENABLE != 0 ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
  assign keep_ext = KEEP_MAX'(keep_eff);
  // wcnt holds the count of earlier words, so it already equals words-1 on the tlast beat.
  assign len_calc = LEN_W'(int'(wcnt) * KEEP_WIDTH + int'(popcount(keep_ext)));
  assign we       = beat && (state == IDLE || state == RECV) && !full;
  assign unused_user = ^s_axis_tuser;

  axis_frame_rx_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wcnt[AW-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wcnt          <= '0;
      err_sticky    <= 1'b0;
      s_axis_tready <= 1'b0;
      frm_valid     <= 1'b0;
      frm_len       <= '0;
      frm_err       <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      case (state)
        IDLE, RECV: if (beat) begin
          if (full) begin
            err_sticky <= 1'b0;
            drop_cnt   <= drop_cnt + 16'd1;
            wcnt       <= '0;
            state      <= s_axis_tlast ? IDLE : DROP;
          end else if (s_axis_tlast) begin
            wcnt       <= '0;
            err_sticky <= 1'b0;
            if (len_calc == '0 || (err_now && !ERR_FWD)) begin
              state    <= IDLE;
              drop_cnt <= drop_cnt + 16'd1;
            end else begin
              state         <= HOLD;
              s_axis_tready <= 1'b0;
              frm_valid     <= 1'b1;
              frm_len       <= len_calc;
              frm_err       <= ERR_FWD && err_now;
            end
          end else begin
            state      <= RECV;
            wcnt       <= wcnt + WC_W'(1);
            err_sticky <= err_now;
          end
        end
        DROP: if (beat && s_axis_tlast) state <= IDLE;
        HOLD: begin
          if (frm_ready) begin
            state     <= IDLE;
            frm_valid <= 1'b0;
          end else begin
            s_axis_tready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_rx.sv
// Self-checking bench for axis_frame_rx: vector table, hand sequences, randomized frames vs model.
module tb_axis_frame_rx;

`ifdef AXIS_FRAME_RX_ERR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 0;
  logic [0:0]  s_axis_tuser = '0;
  logic        frm_valid;
  logic        frm_ready = 0;
  logic [8:0]  frm_len;
  logic        frm_err;
  logic [4:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [15:0] drop_cnt;

  axis_frame_rx dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_len(frm_len), .frm_err(frm_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_drops = '0;
  logic [63:0] words[$];

  typedef struct {
    int         nb;
    logic [7:0] keep;
    int         errbeat;
    bit         hold;
    int         len;
    bit         err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a beat at a negedge and return once tready is seen high (accept at next posedge).
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last,
                           input bit err, output int stalls);
    @(negedge clk);
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last;
    s_axis_tuser = err; s_axis_tvalid = 1;
    stalls = 0;
    while (!s_axis_tready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
  endtask

  task automatic send_frame(input int nb, input logic [7:0] lk, input int eb);
    int st, tot;
    logic [63:0] w;
    tot = 0;
    words.delete();
    for (int b = 0; b < nb; b++) begin
      w = {$urandom, $urandom};
      words.push_back(w);
      send_beat(w, (b == nb - 1) ? lk : 8'($urandom), b == nb - 1, b == eb, st);
      tot += st;
    end
    @(negedge clk);
    s_axis_tvalid = 0;
    chk("no_stall", 64'(tot), 0);
  endtask

  task automatic handshake();
    frm_ready = 1;
    @(negedge clk);
    frm_ready = 0;
    chk("valid_after_hs", frm_valid, 0);
    chk("tready_after_hs", s_axis_tready, 1);
    chk("drop_cnt_hold", drop_cnt, exp_drops);
  endtask

  // Called at the negedge right after the tlast beat was accepted.
  task automatic check_desc(input bit eh, input int el, input bit ee, input bit hs);
    chk("frm_valid", frm_valid, eh);
    chk("tready_after_last", s_axis_tready, !eh);
    if (eh) begin
      chk("frm_len", frm_len, 64'(el));
      chk("frm_err", frm_err, ee);
      for (int i = 0; i < words.size(); i++) begin
        rd_addr = 5'(i);
        @(negedge clk);
        chk("rd_data", rd_data, words[i]);
      end
      chk("frm_valid_stable", frm_valid, 1);
      if (hs) handshake();
    end else begin
      exp_drops++;
      chk("drop_cnt", drop_cnt, exp_drops);
    end
  endtask

  function automatic int model_len(input int nb, input logic [7:0] k);
    return (nb - 1) * 8 + $countones(k);
  endfunction

  initial begin
    vec_t tbl[7];
    int st, hi, nb, eb, len;
    logic [7:0] k;
    bit hold;

    tbl[0] = '{3,  8'h0F, -1, 1'b1, 20,  1'b0};
    tbl[1] = '{1,  8'hFF, -1, 1'b1, 8,   1'b0};
    tbl[2] = '{1,  8'h00, -1, 1'b0, 0,   1'b0};
    tbl[3] = '{4,  8'hFF, 1,  FWD,  32,  FWD};
    tbl[4] = '{33, 8'hFF, -1, 1'b0, 0,   1'b0};
    tbl[5] = '{2,  8'h01, -1, 1'b1, 9,   1'b0};
    tbl[6] = '{32, 8'h80, -1, 1'b1, 249, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_valid", frm_valid, 0);
    chk("rst_len", frm_len, 0);
    chk("rst_err", frm_err, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 0;
    @(negedge clk);
    chk("tready_after_rst", s_axis_tready, 1);

    // Reset during beat 3 of a frame
    send_beat({$urandom, $urandom}, 8'hFF, 0, 0, st);
    send_beat({$urandom, $urandom}, 8'hFF, 0, 0, st);
    @(negedge clk);
    s_axis_tdata = {$urandom, $urandom}; s_axis_tlast = 0; rst = 1;
    @(negedge clk);
    chk("midrst_tready_low", s_axis_tready, 0);
    rst = 0; s_axis_tvalid = 0;
    @(negedge clk);
    chk("midrst_tready_high", s_axis_tready, 1);
    chk("midrst_no_desc", frm_valid, 0);
    chk("midrst_drop_cnt", drop_cnt, exp_drops);

    // Vector table (first entry also proves the post-reset frame starts at address 0)
    foreach (tbl[i]) begin
      send_frame(tbl[i].nb, tbl[i].keep, tbl[i].errbeat);
      check_desc(tbl[i].hold, tbl[i].len, tbl[i].err, 1);
    end

    // Frame 1 held 10 cycles while frame 2 waits
    send_frame(2, 8'hFF, -1);
    check_desc(1, 16, 0, 0);
    words.delete();
    for (int b = 0; b < 3; b++) words.push_back({$urandom, $urandom});
    s_axis_tdata = words[0]; s_axis_tkeep = 8'hFF; s_axis_tlast = 0;
    s_axis_tuser = 0; s_axis_tvalid = 1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_axis_tready || !frm_valid) hi++;
    end
    chk("bp_tready_low", 64'(hi), 0);
    handshake();
    send_beat(words[1], 8'hFF, 0, 0, st);
    send_beat(words[2], 8'h3F, 1, 0, st);
    @(negedge clk);
    s_axis_tvalid = 0;
    check_desc(1, 22, 0, 1);

    // Single full beat with frm_ready held high: 2-cycle turnaround
    frm_ready = 1;
    send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1, 0, st);
    @(negedge clk);
    s_axis_tvalid = 0;
    chk("gap_valid", frm_valid, 1);
    chk("gap_len", frm_len, 8);
    chk("gap_tready_low", s_axis_tready, 0);
    @(negedge clk);
    chk("gap_valid_clr", frm_valid, 0);
    chk("gap_tready_high", s_axis_tready, 1);
    frm_ready = 0;

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 36)) : int'($urandom_range(1, 32));
      k  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      len  = model_len(nb, k);
      hold = (nb <= 32) && (len > 0) && (eb < 0 || FWD);
      send_frame(nb, k, eb);
      check_desc(hold, len, FWD && eb >= 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

endmodule

// File: doc/axis_frame_rx.md
# axis_frame_rx

Terminating AXI4-Stream receiver that accepts one frame at a time into a local word buffer. It then publishes a frame descriptor (byte length, error flag) through a valid/ready handshake. It sits at the consumer end of stream pipelines built from our stream registers and FIFOs, and hands complete frames to a CPU-side or engine-side reader through a synchronous read port. Oversized frames and frames with errors are discarded whole; partial frames are never exposed.

## Interface
- DATA_WIDTH, 64, stream data width in bits
- KEEP_ENABLE, (DATA_WIDTH>8), use tkeep; when 0, every beat is treated as full
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
- USER_WIDTH, 1, tuser width; tuser[0] is the frame-error bit
- DEPTH, 32, buffer depth in words (power of 2, ≥2)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tkeep  in  KEEP_WIDTH  byte enables; only meaningful on the tlast beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept (registered)
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  USER_WIDTH  bit 0 = error
- frm_valid  out  1  descriptor valid
- frm_ready  in  1  descriptor consumed; buffer released
- frm_len  out  $clog2(DEPTH*KEEP_WIDTH+1)  frame length in bytes
- frm_err  out  1  frame carried an error (see Configuration)
- rd_addr  in  $clog2(DEPTH)  buffer word read address
- rd_data  out  DATA_WIDTH  buffer word, 1-cycle latency
- drop_cnt  out  16  dropped-frame counter, wraps at 2^16

## Operation
- States: IDLE (no beat of current frame yet), RECV, DROP, HOLD.
- A beat is accepted when tvalid && tready. Each accepted beat in IDLE/RECV is written to word address wcnt, and wcnt is incremented.
- err_sticky is set by tuser[0] on any accepted beat of the frame and cleared on leaving the frame.
- IDLE → RECV on an accepted beat without tlast.
- IDLE/RECV, accepted beat with wcnt==DEPTH (the buffer is already full) → DROP, and the beat is not written. If that beat also has tlast, the frame is dropped immediately → IDLE.
- IDLE/RECV, accepted tlast beat within capacity:
  - length = (words−1)·KEEP_WIDTH + popcount(tkeep); tkeep is all ones when KEEP_ENABLE=0.
  - If length==0 or the frame is errored (and not forwarded): drop → IDLE.
  - Otherwise → HOLD.
- DROP: tready stays high and beats are discarded until tlast; the tlast beat → IDLE.
- HOLD: frm_valid=1 and frm_len/frm_err are stable. On frm_valid && frm_ready → IDLE, with wcnt=0.
- A drop increments drop_cnt by 1. The increment happens in the cycle after the beat that decides the drop.
- rd_data = buffer[rd_addr] registered. Contents are defined only while in HOLD, for addresses below the frame's word count.

## Timing
- Reset values:
  - s_axis_tready=0, frm_valid=0, frm_len=0, frm_err=0, drop_cnt=0.
  - State IDLE, wcnt=0. rd_data is undefined.
- tready_reg <= (next_state != HOLD) && !rst. tready is high the first cycle after rst deasserts.
- tlast accepted at cycle T (HOLD path) → frm_valid=1 and tready=0 at T+1.
- Handshake at cycle H → frm_valid=0 and tready=1 at H+1.
- Minimum gap between frames is 2 cycles when frm_ready is held high.
- rd_addr sampled at cycle C → rd_data valid at C+1.
- Reset mid-frame abandons the frame without raising a descriptor or counting a drop. The next frame is written from address 0.
- frm_ready outside HOLD is ignored.

## Configuration
- AXIS_FRAME_RX_ERR_FWD_EN defined: errored frames within capacity go to HOLD with frm_err=1 and the true frm_len. They are not counted in drop_cnt.
- AXIS_FRAME_RX_ERR_FWD_EN undefined: errored frames are dropped and counted. frm_err is tied to 0.
- Oversize frames and zero-length frames are dropped in both cases.

## Structure
- Package axis_frame_rx_pkg holds:
  - the state enum (IDLE, RECV, DROP, HOLD);
  - a width function for frm_len;
  - the popcount function for tkeep.
- Sub-module axis_frame_rx_ram holds the buffer: a simple dual-port RAM (1 write port, 1 registered read port), DEPTH×DATA_WIDTH, with no reset on its storage.

## Test plan
- DATA_WIDTH=64, 3-beat frame, last tkeep=0x0F → frm_len=20, frm_err=0; rd_addr 0,1,2 returns the three data words one cycle later.
- Frame 1 held with frm_ready=0 for 10 cycles while frame 2 is presented → tready=0 throughout; frame 2 is accepted starting the cycle after the handshake and its data is intact.
- DEPTH=32, 33-beat frame → no frm_valid, drop_cnt 0→1, tready high for all 33 beats; the following 2-beat frame is received normally.
- tuser[0]=1 on beat 2 of a 4-beat frame, full last tkeep:
  - without the macro → dropped, drop_cnt+1;
  - with the macro → frm_err=1, frm_len=32.
- rst pulsed during beat 3 of a frame → tready=0 during rst and 1 one cycle after; no descriptor, drop_cnt unchanged; the next frame is read back from address 0.
- Single-beat frame with tkeep=0x00 → dropped, drop_cnt+1. Single-beat frame with tkeep=0xFF and frm_ready held high → frm_len=8 and tready returns high 2 cycles after tlast.
